llr_extr_sched: RTL
===================

Name: llr_extr_sched

Overview:
- Frame-level sequencer for the LLR/extrinsic calculation pipeline inside the SISO decoder.
- On a start command it reads the stored alpha/beta/branch/sys buffers once per trellis step, in descending address order (k = N-1 down to 0).
- It drives the pipeline's sof/eof/valid inputs aligned to the buffer read data, counts the pipeline's LLR outputs and reports frame completion or error.

Parameters:
- AWIDTH, 12, buffer address width; frame length 1..2^AWIDTH-1.
- RD_LATENCY, 2, cycles from o_rd_en to buffer read data valid (range 1..8).
- CALC_LATENCY, 9, cycles from pipeline input valid to o_valid_llr (informational; sets watchdog).
- WDOG_SLACK, 4, extra idle cycles tolerated in DRAIN before error.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- i_start  in  1  single-cycle frame start request.
- i_frame_len  in  AWIDTH  frame length N, sampled when start is accepted.
- i_hold  in  1  upstream stall; suppresses read issue while high.
- o_busy  out  1  high from start accept until o_done.
- o_rd_en  out  1  buffer read strobe.
- o_rd_addr  out  AWIDTH  buffer read address.
- o_calc_sof  out  1  pipeline i_sof, aligned to read data.
- o_calc_eof  out  1  pipeline i_eof, aligned to read data.
- o_calc_valid  out  1  pipeline i_valid, aligned to read data.
- i_llr_valid  in  1  pipeline o_valid_llr.
- i_llr_eof  in  1  pipeline o_eof_llr.
- o_done  out  1  one-cycle frame-complete pulse.
- o_err  out  1  sticky error flag.

Behaviour:
- Reset (async, aresetn=0):
  - State IDLE; all outputs 0; o_rd_addr 0; counters and alignment pipeline cleared.
  - Reset mid-frame aborts immediately with no o_done.
- Clocking: all logic on posedge aclk.
- FSM states: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE:
  - i_start=1 with N>=1: latch N, clear o_err and counters, assert o_busy next cycle, go ISSUE.
  - i_start=1 with N=0: set o_err, stay IDLE, no reads.
- ISSUE:
  - Each cycle with i_hold=0: o_rd_en=1, o_rd_addr = issue counter, which starts at N-1 and decrements.
  - The first read is tagged sof; the read at address 0 is tagged eof.
  - After the read at address 0 is issued, go DRAIN.
  - i_hold=1: o_rd_en=0, counter holds. Bubbles are legal because the pipeline is free-running.
  - N=1: a single read carries both sof and eof.
- Alignment:
  - {rd_en, sof, eof} pass through a RD_LATENCY-stage shift register to o_calc_valid/sof/eof.
  - Tags are registered outputs and are always gated by valid.
  - The shift register keeps shifting in every state, so tail entries drain after ISSUE ends.
- Output counting:
  - An out counter increments on every i_llr_valid while o_busy.
  - When i_llr_valid & i_llr_eof, compare out count+1 to N; on mismatch set o_err.
  - i_llr_valid seen outside o_busy sets o_err.
- DRAIN:
  - Wait until out count reaches N, then go DONE.
  - A watchdog reloads with RD_LATENCY+CALC_LATENCY+WDOG_SLACK on each i_llr_valid and on DRAIN entry.
  - On watchdog expiry: set o_err, go DONE.
- DONE: o_done=1 for one cycle, o_busy=0 in the same cycle, go IDLE.
- i_start while o_busy is ignored; no queueing, no error.
- o_err is sticky until the next accepted start or reset.
- Counter arithmetic:
  - Unsigned, AWIDTH bits (out count AWIDTH+1 bits).
  - The issue counter never wraps because ISSUE exits at address 0.

Optional Feature:
- Macro: LLR_EXTR_SCHED_PERF_EN.
- Defined:
  - Adds output port o_cycle_count, 32 bits.
  - It clears on start accept and increments every cycle while o_busy; it saturates at 2^32-1.
  - It holds its value after o_done until the next start; reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- N=4, i_hold=0:
  - Reads at addresses 3,2,1,0 on consecutive cycles.
  - o_calc_valid is high 4 cycles, starting 2 cycles after the first o_rd_en; sof with address 3, eof with address 0.
  - The model returns 4 outputs at latency 9; o_done fires 1 cycle after the 4th output; o_err=0.
- N=1: one read at address 0 with sof=eof=1 on the same o_calc_valid cycle; o_done after the single output.
- N=6, i_hold high on cycles 2 and 3 of ISSUE: addresses 5,4,(gap),(gap),3,2,1,0 appear with matching valid gaps; output count reaches 6; o_done; o_err=0.
- N=5 where the model returns only 4 outputs:
  - Watchdog expires 15 cycles after the last output; o_err=1, o_done pulses.
  - The next start with N=2 clears o_err.
- Start with N=0, then a start while busy (N=8 frame running, second i_start with N=3):
  - The first sets o_err with no reads.
  - The second is ignored; exactly 8 reads are issued.
- aresetn pulsed low mid-ISSUE (N=16, after 5 reads): all outputs 0 immediately, no o_done; with PERF_EN, o_cycle_count=0; a new frame after reset completes normally.

Source files
------------

// File: rtl/llr_extr_sched_if.sv
// llr_extr_sched_if: start/read/pipeline/status bundle for the LLR extrinsic sequencer.
// o_cycle_count exists only when LLR_EXTR_SCHED_PERF_EN is defined.
`timescale 1ns/1ps
interface llr_extr_sched_if #(parameter int AWIDTH = 12);
  logic              i_start;
  logic [AWIDTH-1:0] i_frame_len;
  logic              i_hold;
  logic              o_busy;
  logic              o_rd_en;
  logic [AWIDTH-1:0] o_rd_addr;
  logic              o_calc_sof;
  logic              o_calc_eof;
  logic              o_calc_valid;
  logic              i_llr_valid;
  logic              i_llr_eof;
  logic              o_done;
  logic              o_err;
`ifdef LLR_EXTR_SCHED_PERF_EN
  logic [31:0]       o_cycle_count;
`endif
  modport slave (
    input  i_start, i_frame_len, i_hold, i_llr_valid, i_llr_eof,
    output o_busy, o_rd_en, o_rd_addr, o_calc_sof, o_calc_eof, o_calc_valid, o_done, o_err
`ifdef LLR_EXTR_SCHED_PERF_EN
    , output o_cycle_count
`endif
  );
  modport master (
    output i_start, i_frame_len, i_hold, i_llr_valid, i_llr_eof,
    input  o_busy, o_rd_en, o_rd_addr, o_calc_sof, o_calc_eof, o_calc_valid, o_done, o_err
`ifdef LLR_EXTR_SCHED_PERF_EN
    , input o_cycle_count
`endif
  );
endinterface

// File: rtl/llr_extr_sched.sv
// llr_extr_sched: frame sequencer reading trellis buffers N-1..0, tagging the LLR pipeline and checking its output count.
// Optional LLR_EXTR_SCHED_PERF_EN adds a saturating busy-cycle counter.
`timescale 1ns/1ps
module llr_extr_sched #(
  parameter int AWIDTH       = 12,
  parameter int RD_LATENCY   = 2,
  parameter int CALC_LATENCY = 9,
  parameter int WDOG_SLACK   = 4
) (
  input logic aclk,
  input logic aresetn,
  llr_extr_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam int WD = RD_LATENCY + CALC_LATENCY + WDOG_SLACK;
  localparam int WW = $clog2(WD + 1);
  state_t state_q, state_d;
  logic [AWIDTH-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [AWIDTH:0] out_q, out_d;
  logic [WW-1:0] wd_q, wd_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, first_q, first_d;
  logic [RD_LATENCY-1:0] v_q, v_d, s_q, s_d, e_q, e_d;
  logic accept, rd;
`ifdef LLR_EXTR_SCHED_PERF_EN
  logic [31:0] cyc_q, cyc_d;
`endif
  always_comb begin
    accept = state_q == IDLE && bus.i_start && bus.i_frame_len != '0;
    rd = state_q == ISSUE && !bus.i_hold;
    state_d = state_q;
    len_d = accept ? bus.i_frame_len : len_q;
    cnt_d = accept ? bus.i_frame_len - AWIDTH'(1) : (rd && cnt_q != '0) ? cnt_q - AWIDTH'(1) : cnt_q;
    first_d = accept | (first_q & ~rd);
    out_d = accept ? '0 : (busy_q && bus.i_llr_valid) ? out_q + 1'b1 : out_q;
    busy_d = busy_q | accept;
    done_d = 1'b0;
    wd_d = wd_q;
    err_d = accept ? 1'b0 : err_q | (state_q == IDLE && bus.i_start && bus.i_frame_len == '0)
          | (bus.i_llr_valid && !busy_q)
          | (bus.i_llr_valid && bus.i_llr_eof && busy_q && out_q + 1'b1 != {1'b0, len_q});
    // tags enter the alignment line already gated by the read strobe
    v_d = RD_LATENCY'({v_q, rd});
    s_d = RD_LATENCY'({s_q, rd & first_q});
    e_d = RD_LATENCY'({e_q, rd && cnt_q == '0});
    case (state_q)
      IDLE: state_d = accept ? ISSUE : IDLE;
      ISSUE: if (rd && cnt_q == '0) begin
        state_d = DRAIN;
        wd_d = WW'(WD);
      end
      DRAIN: if (out_d >= {1'b0, len_q}) begin
        state_d = DONE;
        done_d = 1'b1;
        busy_d = 1'b0;
      end else if (bus.i_llr_valid) begin
        wd_d = WW'(WD);
      end else if (wd_q <= WW'(1)) begin
        state_d = DONE;
        done_d = 1'b1;
        busy_d = 1'b0;
        err_d = 1'b1;
      end else begin
        wd_d = wd_q - WW'(1);
      end
      default: state_d = IDLE;
    endcase
`ifdef LLR_EXTR_SCHED_PERF_EN
    cyc_d = accept ? '0 : (busy_q && !(&cyc_q)) ? cyc_q + 32'd1 : cyc_q;
`endif
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      len_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
      wd_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      first_q <= 1'b0;
      v_q <= '0;
      s_q <= '0;
      e_q <= '0;
`ifdef LLR_EXTR_SCHED_PERF_EN
      cyc_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      wd_q <= wd_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      first_q <= first_d;
      v_q <= v_d;
      s_q <= s_d;
      e_q <= e_d;
`ifdef LLR_EXTR_SCHED_PERF_EN
      cyc_q <= cyc_d;
`endif
    end
  end
  assign bus.o_busy = busy_q;
  assign bus.o_done = done_q;
  assign bus.o_err = err_q;
  assign bus.o_rd_en = rd;
  assign bus.o_rd_addr = cnt_q;
  assign bus.o_calc_valid = v_q[RD_LATENCY-1];
  assign bus.o_calc_sof = s_q[RD_LATENCY-1] & v_q[RD_LATENCY-1];
  assign bus.o_calc_eof = e_q[RD_LATENCY-1] & v_q[RD_LATENCY-1];
`ifdef LLR_EXTR_SCHED_PERF_EN
  assign bus.o_cycle_count = cyc_q;
`endif
endmodule
